// File: rtl/seq_normalizer_if.sv
// Handshake and data bundle for seq_normalizer: operand in, normalized result out.
interface seq_normalizer_if #(
    parameter int BUSWIDTH   = 32,
    parameter int SHIFTWIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BUSWIDTH-1:0]   data_in;
    logic                  direction;
    logic                  out_valid;
    logic                  out_ready;
    logic [BUSWIDTH-1:0]   data_out;
    logic [SHIFTWIDTH-1:0] shift_cnt;
    logic                  zero;

    modport master (
        output in_valid, data_in, direction, out_ready,
        input  in_ready, out_valid, data_out, shift_cnt, zero
    );

    modport slave (
        input  in_valid, data_in, direction, out_ready,
        output in_ready, out_valid, data_out, shift_cnt, zero
    );
endinterface

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand one bit per cycle until the target
// end bit is set, reporting the shift count and an all-zero flag.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | shifting working register toward the target bit
// DONE  | result presented, waiting for out_ready
module seq_normalizer #(
    parameter int BUSWIDTH   = 32,
    parameter int SHIFTWIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_normalizer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [BUSWIDTH-1:0]   work;
    logic                  dir;
    logic [SHIFTWIDTH-1:0] cnt;
    logic                  out_valid_q;
    logic [BUSWIDTH-1:0]   data_out_q;
    logic [SHIFTWIDTH-1:0] shift_cnt_q;
    logic                  zero_q;
    logic                  target_bit;

    assign target_bit    = dir ? work[0] : work[BUSWIDTH-1];
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.shift_cnt = shift_cnt_q;
    assign bus.zero      = zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            dir         <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            shift_cnt_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work <= bus.data_in;
                        dir  <= bus.direction;
                        cnt  <= '0;
                        // An all-zero operand can never reach its target bit.
                        if (bus.data_in == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            data_out_q  <= '0;
                            shift_cnt_q <= '0;
                            zero_q      <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (target_bit) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        data_out_q  <= work;
                        shift_cnt_q <= cnt;
                        zero_q      <= 1'b0;
                    end else begin
                        work <= dir ? (work >> 1) : (work << 1);
                        cnt  <= cnt + SHIFTWIDTH'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: driver pushes expected results, monitor
// pops and checks on each new output, plus stall, reset-abort and reset checks.
module tb_seq_normalizer;
    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
        logic        z;
        int          t0;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic prev_valid = 1'b0;

    seq_normalizer_if #(.BUSWIDTH(32), .SHIFTWIDTH(5)) bus ();

    seq_normalizer #(.BUSWIDTH(32), .SHIFTWIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: each rising out_valid pops one expectation; held results must stay stable.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (!prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.data_out), 64'hDEAD);
                end else begin
                    cur = q.pop_front();
                    chk("data_out", 64'(bus.data_out), 64'(cur.d));
                    chk("shift_cnt", 64'(bus.shift_cnt), 64'(cur.c));
                    chk("zero", 64'(bus.zero), 64'(cur.z));
                    chk("latency", 64'(cycle - cur.t0), 64'(cur.c) + (cur.z ? 64'd0 : 64'd1));
                end
            end else begin
                chk("hold_data", 64'(bus.data_out), 64'(cur.d));
                chk("hold_cnt", 64'(bus.shift_cnt), 64'(cur.c));
                chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            end
        end
        prev_valid = bus.out_valid;
    end

    // Present an operand, wait for acceptance, optionally queue its expected result.
    task automatic send(input logic [31:0] d, input logic dir,
                        input logic [31:0] ed, input logic [4:0] ec, input logic ez,
                        input bit push, input bit keep);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.direction = dir;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 64'(n), 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        e.d = ed; e.c = ec; e.z = ez; e.t0 = cycle + 1;
        if (push) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
        bus.data_in   = $urandom;
        bus.direction = ~dir;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.direction = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_shift_cnt", 64'(bus.shift_cnt), 64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        send(32'h0000_1000, 1'b0, 32'h8000_0000, 5'd19, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0001, 1'b0, 32'h8000_0001, 5'd0,  1'b0, 1'b1, 1'b0);
        send(32'h0000_1000, 1'b1, 32'h0000_0001, 5'd12, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, 1'b1, 1'b0);
        send(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 1'b1, 1'b0);
        send(32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b1, 1'b0);
        send(32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0, 1'b1, 1'b0);
        send(32'h00F0_0000, 1'b1, 32'h0000_000F, 5'd20, 1'b0, 1'b1, 1'b0);

        // Stall the consumer with in_valid held high and data_in churning.
        n = 0;
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        bus.out_ready = 1'b0;
        send(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            bus.data_in = $urandom;
            n++;
        end
        chk("stall_wait_timeout", 64'(n >= 200), 64'd0);
        repeat (5) begin
            @(negedge clk);
            bus.data_in = $urandom;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_hs_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_after_hs_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;

        // Abort an operation mid-shift; its result must never appear.
        send(32'h0000_0001, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_data_out", 64'(bus.data_out), 64'd0);
        chk("abort_shift_cnt", 64'(bus.shift_cnt), 64'd0);
        chk("abort_zero", 64'(bus.zero), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = 32'h0000_0300;
        bus.direction = 1'b1;
        rst_n         = 1'b1;
        q.push_back('{d: 32'h0000_0003, c: 5'd8, z: 1'b0, t0: cycle + 1});
        #1 chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = $urandom;
        chk("accept_first_edge", 64'(bus.in_ready), 64'd0);

        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32, giving the data path width in bits.
REQ-002 SHALL have parameter SHIFTWIDTH, default 5, giving the shift-count width; it SHALL be at least clog2(BUSWIDTH).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  data_in and direction are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port data_in  input  BUSWIDTH  operand to normalize.
REQ-008 SHALL have port direction  input  1  0 = normalize toward MSB (left), 1 = normalize toward LSB (right).
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port data_out  output  BUSWIDTH  normalized operand.
REQ-012 SHALL have port shift_cnt  output  SHIFTWIDTH  number of bit positions shifted.
REQ-013 SHALL have port zero  output  1  operand was all zeros.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready high only in IDLE, as a combinational decode of the state register.
REQ-016 SHALL accept an operand on a rising edge where in_valid and in_ready are both 1, called edge t0.
REQ-017 At acceptance SHALL latch data_in into a working register, latch direction, and clear the count.
REQ-018 At acceptance with data_in == 0 SHALL go to DONE with zero=1, data_out=0 and shift_cnt=0, so out_valid is high after t0.
REQ-019 At acceptance with nonzero data_in SHALL go to SHIFT.
REQ-020 In SHIFT, at each edge, if the target bit is 1 SHALL go to DONE without shifting; the target bit is bit BUSWIDTH-1 for direction=0 and bit 0 for direction=1.
REQ-021 In SHIFT, if the target bit is 0, SHALL shift the working register by exactly one bit toward the target, fill the vacated bit with 0, and increment the count.
REQ-022 Latency SHALL be shift_cnt+1 cycles from t0 to out_valid for nonzero operands; the maximum is BUSWIDTH cycles.
REQ-023 The count SHALL never exceed BUSWIDTH-1 and SHALL never wrap.
REQ-024 In DONE SHALL hold out_valid=1 and keep data_out, shift_cnt and zero stable until out_ready=1.
REQ-025 When out_valid and out_ready are both 1 on a rising edge SHALL return to IDLE and deassert out_valid.
REQ-026 SHALL NOT accept a new operand in the same cycle as the output handshake, giving a minimum of one IDLE cycle between operations.
REQ-027 SHALL ignore in_valid while in SHIFT or DONE.
REQ-028 data_out, shift_cnt and zero SHALL be registered outputs and SHALL change only on entry to DONE or on reset.
REQ-029 SHALL ignore changes on data_in and direction after acceptance.

Reset
REQ-030 When rst_n=0, SHALL asynchronously force state IDLE, out_valid=0, data_out=0, shift_cnt=0 and zero=0; in_ready is then 1.
REQ-031 Reset asserted in SHIFT or DONE SHALL abort the operation with no result ever presented.
REQ-032 SHALL accept an operand on the first rising edge after rst_n deasserts if in_valid=1.

Verification
REQ-033 With BUSWIDTH=32, SHIFTWIDTH=5: data_in=0x0000_1000, direction=0, out_ready=1 -> data_out=0x8000_0000, shift_cnt=19, zero=0, out_valid at t0+20.
REQ-034 data_in=0x8000_0001, direction=0 -> data_out=0x8000_0001, shift_cnt=0, out_valid at t0+1.
REQ-035 data_in=0x0000_1000, direction=1 -> data_out=0x0000_0001, shift_cnt=12, out_valid at t0+13.
REQ-036 data_in=0x0000_0000, either direction -> zero=1, data_out=0, shift_cnt=0, out_valid after t0.
REQ-037 data_in=0x0000_0001, direction=0, out_ready held 0 for 5 cycles after out_valid, with in_valid=1 throughout -> data_out=0x8000_0000 and shift_cnt=31 stable, in_ready=0, no second acceptance; IDLE one edge after out_ready=1.
REQ-038 rst_n pulsed low 3 cycles into SHIFT -> all outputs at reset values immediately, out_valid never asserts for that operand, in_ready=1 after release.
